i2c_xfer_buffer: RTL

//  Host-side front end that sits directly upstream of i2c_master and feeds it.

---
 rtl/i2c_xfer_buffer_if.sv | 69 ++++++
 rtl/i2c_xfer_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_buffer_if.sv
// Host/master-facing signal bundle for i2c_xfer_buffer.
// The slave modport is the buffer's view. The master modport is the view of
// whoever drives the buffer: host logic, the i2c_master wrapper, or a bench.
//
// Handshake rules:
//  - A host push (i_tx_wr_en) or pop (i_rx_rd_en) takes effect on the rising
//    edge where it is high. o_tx_full and o_rx_empty tell the host whether it
//    will be accepted. A rejected push or pop is dropped silently.
//  - i_go is a single-cycle request. It is only looked at while the buffer is idle.
//  - i_m_rx_data_valid and i_m_done are single-cycle strobes. Each high cycle is one event.
//  - i_m_tx_data_needed is a level. Only its low-to-high transition is an event.
interface i2c_xfer_buffer_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 10
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // host TX side
  logic                  i_tx_wr_en;
  logic [7:0]            i_tx_wr_data;
  logic                  o_tx_full;
  logic [LW-1:0]         o_tx_level;
  // host RX side
  logic                  i_rx_rd_en;
  logic [7:0]            o_rx_rd_data;
  logic                  o_rx_empty;
  logic [LW-1:0]         o_rx_level;
  // host control/status
  logic                  i_go;
  logic [ADDR_WIDTH-1:0] i_slave_addr;
  logic                  i_read;
  logic [7:0]            i_byte_cnt;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;
  // master side
  logic                  o_m_start;
  logic [ADDR_WIDTH-1:0] o_m_slave_addr;
  logic                  o_m_read;
  logic [7:0]            o_m_byte_cnt;
  logic [7:0]            o_m_tx_data;
  logic                  i_m_tx_data_needed;
  logic                  i_m_rx_data_valid;
  logic [7:0]            i_m_rx_data;
  logic                  i_m_done;
  logic                  i_m_nack;
  // FSM state for observation
  logic [2:0]            o_dbg_state;

  modport slave (
    input  i_tx_wr_en, i_tx_wr_data, i_rx_rd_en,
    input  i_go, i_slave_addr, i_read, i_byte_cnt,
    input  i_m_tx_data_needed, i_m_rx_data_valid, i_m_rx_data, i_m_done, i_m_nack,
    output o_tx_full, o_tx_level, o_rx_rd_data, o_rx_empty, o_rx_level,
    output o_busy, o_done, o_err,
    output o_m_start, o_m_slave_addr, o_m_read, o_m_byte_cnt, o_m_tx_data,
    output o_dbg_state
  );

  modport master (
    output i_tx_wr_en, i_tx_wr_data, i_rx_rd_en,
    output i_go, i_slave_addr, i_read, i_byte_cnt,
    output i_m_tx_data_needed, i_m_rx_data_valid, i_m_rx_data, i_m_done, i_m_nack,
    input  o_tx_full, o_tx_level, o_rx_rd_data, o_rx_empty, o_rx_level,
    input  o_busy, o_done, o_err,
    input  o_m_start, o_m_slave_addr, o_m_read, o_m_byte_cnt, o_m_tx_data,
    input  o_dbg_state
  );
endinterface

// File: rtl/i2c_xfer_buffer.sv
// Host-side front end for i2c_master.
// Write bytes are buffered in a TX FIFO and read bytes in an RX FIFO.
// One master transaction is launched per accepted i_go. Per-byte data
// requests from the master are answered here, and completion/error is
// reported back to the host.
module i2c_xfer_buffer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  i2c_xfer_buffer_if.slave      bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [LW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_pop_req;
  logic [7:0]    tx_head;

  assign tx_full  = (tx_cnt == LW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_pop   = tx_pop_req && !tx_empty;
  // A pop in the same cycle frees a slot, so a push at full still fits.
  assign tx_push  = bus.i_tx_wr_en && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rptr];

  // TX storage write; contents need no reset because the pointers gate them
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wptr] <= bus.i_tx_wr_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + LW'(1);
      else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - LW'(1);
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [LW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_push_req;
  logic [7:0]    rx_last;

  assign rx_full  = (rx_cnt == LW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = bus.i_rx_rd_en && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);

  // RX storage write
  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wptr] <= bus.i_m_rx_data;
  end

  // RX pointers, occupancy, and the last popped byte (shown while empty)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
      rx_last <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop) begin
        rx_rptr <= rx_rptr + AW'(1);
        rx_last <= rx_mem[rx_rptr];
      end
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + LW'(1);
      else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - LW'(1);
    end
  end

  // ---------------- transaction control ----------------
  logic [ADDR_WIDTH-1:0] m_addr;
  logic                  m_read;
  logic [7:0]            m_cnt;
  logic [7:0]            m_tx_data;
  logic [7:0]            remaining;
  logic                  mismatch, nack_q, err_rej, needed_q;
  logic                  needed_rise, bad_req;
  logic                  accept, reject, load_byte, zero_byte, dec, set_mm, finish;

  assign needed_rise = bus.i_m_tx_data_needed && !needed_q;

  assign bad_req = (bus.i_byte_cnt == 8'd0) ||
                   (!bus.i_read && (32'(tx_cnt) < 32'(bus.i_byte_cnt))) ||
                   (bus.i_read &&
                    ((32'(FIFO_DEPTH) - 32'(rx_cnt)) < 32'(bus.i_byte_cnt)));

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next  = state;
    tx_pop_req  = 1'b0;
    rx_push_req = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    load_byte   = 1'b0;
    zero_byte   = 1'b0;
    dec         = 1'b0;
    set_mm      = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_go) begin
          if (bad_req) begin
            reject = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // Prefetch byte 0 so it is already on o_m_tx_data at start.
        if (!m_read && remaining != 8'd0) begin
          tx_pop_req = 1'b1;
          load_byte  = 1'b1;
          dec        = 1'b1;
        end
        state_next = S_START;
      end
      S_START: begin
        state_next = S_XFER;
      end
      S_XFER: begin
        if (!m_read && needed_rise) begin
          if (remaining != 8'd0) begin
            tx_pop_req = 1'b1;
            load_byte  = 1'b1;
            dec        = 1'b1;
          end else begin
            zero_byte = 1'b1;
            set_mm    = 1'b1;
          end
        end
        if (m_read && bus.i_m_rx_data_valid) begin
          rx_push_req = 1'b1;
          if (remaining != 8'd0) dec    = 1'b1;
          else                   set_mm = 1'b1;
        end
        // A request/strobe in the same cycle as i_m_done counts first.
        if (bus.i_m_done) begin
          finish     = 1'b1;
          state_next = S_DONE;
          if ((remaining - {7'd0, dec}) != 8'd0) set_mm = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Transaction datapath: latched request, byte counter, status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_addr    <= '0;
      m_read    <= 1'b0;
      m_cnt     <= '0;
      m_tx_data <= '0;
      remaining <= '0;
      mismatch  <= 1'b0;
      nack_q    <= 1'b0;
      err_rej   <= 1'b0;
      needed_q  <= 1'b0;
    end else begin
      needed_q <= bus.i_m_tx_data_needed;
      err_rej  <= reject;
      if (accept) begin
        m_addr    <= bus.i_slave_addr;
        m_read    <= bus.i_read;
        m_cnt     <= bus.i_byte_cnt;
        remaining <= bus.i_byte_cnt;
      end else if (dec) begin
        remaining <= remaining - 8'd1;
      end
      if (load_byte)      m_tx_data <= tx_head;
      else if (zero_byte) m_tx_data <= 8'h00;
      if (finish)              nack_q <= bus.i_m_nack;
      else if (state == S_DONE) nack_q <= 1'b0;
      if (set_mm)              mismatch <= 1'b1;
      else if (state == S_DONE) mismatch <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign bus.o_tx_full      = tx_full;
  assign bus.o_tx_level     = tx_cnt;
  assign bus.o_rx_empty     = rx_empty;
  assign bus.o_rx_level     = rx_cnt;
  assign bus.o_rx_rd_data   = rx_empty ? rx_last : rx_mem[rx_rptr];
  assign bus.o_busy         = (state != S_IDLE);
  assign bus.o_done         = (state == S_DONE);
  assign bus.o_err          = err_rej || ((state == S_DONE) && (nack_q || mismatch));
  assign bus.o_m_start      = (state == S_START);
  assign bus.o_m_slave_addr = m_addr;
  assign bus.o_m_read       = m_read;
  assign bus.o_m_byte_cnt   = m_cnt;
  assign bus.o_m_tx_data    = m_tx_data;
  assign bus.o_dbg_state    = state;
endmodule
